// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the hazard controller (slave).
// The optional HAZARD_PERF_EN counters are plain ports of the controller, not part of this bundle.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5
);
  logic             ihit;
  logic             dhit;
  logic             mem_req;
  logic [REG_W-1:0] if_rs;
  logic [REG_W-1:0] if_rt;
  logic             if_uses_rt;
  logic             ex_mem2reg;
  logic             ex_regwen;
  logic [REG_W-1:0] ex_wsel;
  logic             ex_redirect;
  logic             wb_halt;
  logic             advance;
  logic             stall;
  logic             flush;
  logic             pc_en;
  logic             halted;

  modport master (
    output ihit, dhit, mem_req, if_rs, if_rt, if_uses_rt,
           ex_mem2reg, ex_regwen, ex_wsel, ex_redirect, wb_halt,
    input  advance, stall, flush, pc_en, halted
  );

  modport slave (
    input  ihit, dhit, mem_req, if_rs, if_rt, if_uses_rt,
           ex_mem2reg, ex_regwen, ex_wsel, ex_redirect, wb_halt,
    output advance, stall, flush, pc_en, halted
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/advance controller for the IF/ID and ID/EX latches.
// Define HAZARD_PERF_EN to add saturating stall/flush/wait performance counters.
module pipeline_hazard_ctrl #(
  parameter int REG_W = 5
`ifdef HAZARD_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic                    CLK,
  input  logic                    RST,
  pipeline_hazard_ctrl_if.slave   hz
`ifdef HAZARD_PERF_EN
  , output logic [CNT_W-1:0]      stall_cnt
  , output logic [CNT_W-1:0]      flush_cnt
  , output logic [CNT_W-1:0]      wait_cnt
`endif
);

  typedef enum logic [1:0] {RUN, MEMWAIT, HALTED} state_t;

  localparam logic [REG_W-1:0] ZERO_REG = '0;

  state_t state;
  logic   redirect_pend;
  logic   mem_ok, go, lu, redir, stall_c;

  always_comb begin
    mem_ok  = !hz.mem_req || hz.dhit;
    go      = hz.ihit && mem_ok && (state != HALTED);
    lu      = hz.ex_mem2reg && hz.ex_regwen && (hz.ex_wsel != ZERO_REG) &&
              ((hz.ex_wsel == hz.if_rs) || (hz.if_uses_rt && (hz.ex_wsel == hz.if_rt)));
    redir   = hz.ex_redirect || redirect_pend;
    stall_c = go && lu && !redir;
  end

  // Outputs are forced low for as long as reset is asserted
  assign hz.advance = !RST && go;
  assign hz.flush   = !RST && go && redir;
  assign hz.stall   = !RST && stall_c;
  assign hz.pc_en   = !RST && go && !stall_c;
  assign hz.halted  = !RST && (state == HALTED);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= RUN;
      redirect_pend <= 1'b0;
    end else begin
      // A redirect that cannot flush now is remembered until the next go cycle
      if (go && redir)
        redirect_pend <= 1'b0;
      else if (hz.ex_redirect && !go)
        redirect_pend <= 1'b1;

      if (go && hz.wb_halt) begin
        state <= HALTED;
      end else begin
        case (state)
          RUN:     if (hz.ihit && hz.mem_req && !hz.dhit) state <= MEMWAIT;
          MEMWAIT: if (hz.ihit && hz.dhit)                 state <= RUN;
          HALTED:  state <= HALTED;
          default: state <= RUN;
        endcase
      end
    end
  end

`ifdef HAZARD_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // HALTED freezes every counter; the stall and flush conditions already imply go
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else if (state != HALTED) begin
      if (stall_c)     stall_cnt <= sat_inc(stall_cnt);
      if (go && redir) flush_cnt <= sat_inc(flush_cnt);
      if (!go)         wait_cnt  <= sat_inc(wait_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: single-cycle vector table plus multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

  logic CLK = 1'b0;
  logic RST;
  int   checks   = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl_if #(.REG_W(5)) hz ();

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, wait_cnt;
  pipeline_hazard_ctrl #(.REG_W(5)) dut (
    .CLK(CLK), .RST(RST), .hz(hz),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt));
`else
  pipeline_hazard_ctrl #(.REG_W(5)) dut (.CLK(CLK), .RST(RST), .hz(hz));
`endif

  typedef struct {
    logic       ihit, dhit, mem_req;
    logic [4:0] rs, rt;
    logic       uses_rt, mem2reg, regwen;
    logic [4:0] wsel;
    logic       redirect;
    logic       e_adv, e_stall, e_flush, e_pcen;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    hz.ihit = 1'b1; hz.dhit = 1'b1; hz.mem_req = 1'b0;
    hz.if_rs = '0; hz.if_rt = '0; hz.if_uses_rt = 1'b0;
    hz.ex_mem2reg = 1'b0; hz.ex_regwen = 1'b0; hz.ex_wsel = '0;
    hz.ex_redirect = 1'b0; hz.wb_halt = 1'b0;
  endtask

  task automatic chk_outs(input string nm, input logic a, input logic s, input logic f, input logic p);
    chk({nm, ".advance"}, {31'd0, hz.advance}, {31'd0, a});
    chk({nm, ".stall"},   {31'd0, hz.stall},   {31'd0, s});
    chk({nm, ".flush"},   {31'd0, hz.flush},   {31'd0, f});
    chk({nm, ".pc_en"},   {31'd0, hz.pc_en},   {31'd0, p});
  endtask

  // Drive at the falling edge, sample 2 time units later, commit at the next rising edge
  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    cyc(); RST = 1'b1; idle_inputs();
    cyc(); RST = 1'b0;
  endtask

  initial begin
    //            ihit dhit mreq rs  rt  urt m2r rwen wsel red | adv stl fl pce
    vecs[0]  = '{1'b1,1'b1,1'b0,5'd5,5'd0,1'b0,1'b1,1'b1,5'd5,1'b0, 1'b1,1'b1,1'b0,1'b0};
    vecs[1]  = '{1'b1,1'b1,1'b0,5'd5,5'd0,1'b0,1'b0,1'b1,5'd5,1'b0, 1'b1,1'b0,1'b0,1'b1};
    vecs[2]  = '{1'b1,1'b1,1'b0,5'd0,5'd0,1'b0,1'b1,1'b1,5'd0,1'b0, 1'b1,1'b0,1'b0,1'b1};
    vecs[3]  = '{1'b1,1'b1,1'b0,5'd3,5'd5,1'b0,1'b1,1'b1,5'd5,1'b0, 1'b1,1'b0,1'b0,1'b1};
    vecs[4]  = '{1'b1,1'b1,1'b0,5'd3,5'd5,1'b1,1'b1,1'b1,5'd5,1'b0, 1'b1,1'b1,1'b0,1'b0};
    vecs[5]  = '{1'b1,1'b1,1'b0,5'd5,5'd0,1'b0,1'b1,1'b0,5'd5,1'b0, 1'b1,1'b0,1'b0,1'b1};
    vecs[6]  = '{1'b1,1'b1,1'b0,5'd5,5'd0,1'b0,1'b1,1'b1,5'd5,1'b1, 1'b1,1'b0,1'b1,1'b1};
    vecs[7]  = '{1'b1,1'b1,1'b0,5'd1,5'd2,1'b1,1'b0,1'b0,5'd7,1'b1, 1'b1,1'b0,1'b1,1'b1};
    vecs[8]  = '{1'b0,1'b1,1'b0,5'd5,5'd0,1'b0,1'b1,1'b1,5'd5,1'b0, 1'b0,1'b0,1'b0,1'b0};
    vecs[9]  = '{1'b1,1'b1,1'b1,5'd9,5'd0,1'b0,1'b1,1'b1,5'd9,1'b0, 1'b1,1'b1,1'b0,1'b0};
    vecs[10] = '{1'b1,1'b0,1'b1,5'd1,5'd0,1'b0,1'b0,1'b0,5'd0,1'b0, 1'b0,1'b0,1'b0,1'b0};
    vecs[11] = '{1'b1,1'b1,1'b0,5'd1,5'd0,1'b0,1'b0,1'b0,5'd0,1'b0, 1'b1,1'b0,1'b0,1'b1};

    RST = 1'b1;
    idle_inputs();
    hz.ex_mem2reg = 1'b1; hz.ex_regwen = 1'b1; hz.ex_wsel = 5'd5; hz.if_rs = 5'd5;
    hz.ex_redirect = 1'b1;
    repeat (2) cyc();
    #2;
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.halted", {31'd0, hz.halted}, 32'd0);
    cyc(); RST = 1'b0; idle_inputs();

    for (int i = 0; i < 12; i++) begin
      cyc();
      hz.ihit = vecs[i].ihit; hz.dhit = vecs[i].dhit; hz.mem_req = vecs[i].mem_req;
      hz.if_rs = vecs[i].rs; hz.if_rt = vecs[i].rt; hz.if_uses_rt = vecs[i].uses_rt;
      hz.ex_mem2reg = vecs[i].mem2reg; hz.ex_regwen = vecs[i].regwen;
      hz.ex_wsel = vecs[i].wsel; hz.ex_redirect = vecs[i].redirect;
      #2;
      chk_outs($sformatf("vec%0d", i), vecs[i].e_adv, vecs[i].e_stall, vecs[i].e_flush, vecs[i].e_pcen);
    end

    // Memory wait with a redirect pulsed in the first miss cycle
    do_reset();
    for (int c = 0; c < 3; c++) begin
      idle_inputs(); hz.mem_req = 1'b1; hz.dhit = 1'b0; hz.ex_redirect = (c == 0);
      #2;
      chk_outs($sformatf("memwait%0d", c), 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
    end
    idle_inputs(); hz.mem_req = 1'b1; hz.dhit = 1'b1;
    #2; chk_outs("memwait_release", 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(); idle_inputs();
    #2; chk_outs("memwait_after", 1'b1, 1'b0, 1'b0, 1'b1);

    // Redirect re-asserted while pending flushes exactly once
    cyc(); idle_inputs(); hz.ihit = 1'b0; hz.ex_redirect = 1'b1;
    cyc(); idle_inputs(); hz.ihit = 1'b0; hz.ex_redirect = 1'b1;
    #2; chk_outs("pend_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); idle_inputs();
    #2; chk_outs("pend_flush", 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(); idle_inputs();
    #2; chk_outs("pend_once", 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset mid-MEMWAIT discards a pending redirect
    cyc(); idle_inputs(); hz.mem_req = 1'b1; hz.dhit = 1'b0; hz.ex_redirect = 1'b1;
    cyc(); RST = 1'b1; idle_inputs(); hz.mem_req = 1'b1; hz.dhit = 1'b0;
    cyc(); RST = 1'b0; idle_inputs();
    #2; chk_outs("rst_memwait", 1'b1, 1'b0, 1'b0, 1'b1);

    // wb_halt without go is ignored
    cyc(); idle_inputs(); hz.ihit = 1'b0; hz.wb_halt = 1'b1;
    cyc(); idle_inputs();
    #2; chk("halt_nogo", {31'd0, hz.halted}, 32'd0);

    // Halt on a go cycle, then frozen until reset
    cyc(); idle_inputs(); hz.wb_halt = 1'b1;
    #2; chk("halt_go.advance", {31'd0, hz.advance}, 32'd1);
    chk("halt_go.halted", {31'd0, hz.halted}, 32'd0);
    for (int c = 0; c < 10; c++) begin
      cyc(); idle_inputs();
      hz.ihit = 1'($urandom_range(0, 1)); hz.dhit = 1'($urandom_range(0, 1));
      hz.mem_req = 1'($urandom_range(0, 1)); hz.ex_redirect = (c == 3);
      hz.ex_mem2reg = 1'b1; hz.ex_regwen = 1'b1; hz.ex_wsel = 5'd4; hz.if_rs = 5'd4;
      #2;
      chk_outs($sformatf("halted%0d", c), 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("halted%0d.halted", c), {31'd0, hz.halted}, 32'd1);
    end
    cyc(); RST = 1'b1; idle_inputs();
    #2; chk("halt_rst.halted", {31'd0, hz.halted}, 32'd0);
    cyc(); RST = 1'b0; idle_inputs(); hz.ihit = 1'b0;
    #2; chk("after_halt.halted", {31'd0, hz.halted}, 32'd0);
    chk_outs("after_halt_miss", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); idle_inputs();
    #2; chk_outs("after_halt_hit", 1'b1, 1'b0, 1'b0, 1'b1);

`ifdef HAZARD_PERF_EN
    do_reset();
    for (int c = 0; c < 3; c++) begin
      idle_inputs(); hz.ex_mem2reg = 1'b1; hz.ex_regwen = 1'b1; hz.ex_wsel = 5'd6; hz.if_rs = 5'd6;
      cyc();
    end
    for (int c = 0; c < 2; c++) begin
      idle_inputs(); hz.ex_redirect = 1'b1;
      cyc();
    end
    for (int c = 0; c < 4; c++) begin
      idle_inputs(); hz.mem_req = 1'b1; hz.dhit = 1'b0;
      cyc();
    end
    idle_inputs();
    #2;
    chk("perf.stall_cnt", stall_cnt, 32'd3);
    chk("perf.flush_cnt", flush_cnt, 32'd2);
    chk("perf.wait_cnt",  wait_cnt,  32'd4);
    do_reset();
    #2;
    chk("perf_rst.stall_cnt", stall_cnt, 32'd0);
    chk("perf_rst.flush_cnt", flush_cnt, 32'd0);
    chk("perf_rst.wait_cnt",  wait_cnt,  32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and advance controller that produces the stall, flush and advance controls consumed by the IF/ID and ID/EX pipeline latches.
- Gates all pipeline registers on instruction and data cache hits.
- Inserts one bubble on load-use hazards.
- Squashes wrong-path instructions on EX-resolved redirects, holding a redirect pending across memory waits.
- Freezes the pipe permanently once HALT retires in WB.

Parameters:
REG_W, 5, register-index width
CNT_W, 32, performance counter width (optional feature only)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous reset, active-high
ihit  input  1  instruction cache hit this cycle
dhit  input  1  data cache hit for the MEM-stage access
mem_req  input  1  MEM stage holds a load or store (dREN|dWEN)
if_rs  input  REG_W  rs field of the instruction in IF/ID
if_rt  input  REG_W  rt field of the instruction in IF/ID
if_uses_rt  input  1  IF/ID instruction reads rt
ex_mem2reg  input  1  ID/EX instruction is a load
ex_regwen  input  1  ID/EX instruction writes a register
ex_wsel  input  REG_W  ID/EX destination register
ex_redirect  input  1  branch taken or jump resolved in EX
wb_halt  input  1  HALT in WB stage
advance  output  1  pipeline latch enable (hit_check)
stall  output  1  hold PC and IF/ID, bubble ID/EX
flush  output  1  zero IF/ID and ID/EX
pc_en  output  1  PC register write enable
halted  output  1  sticky halt indication

Behaviour:
State machine: RUN, MEMWAIT, HALTED. Registered state, plus a redirect_pend flag.

Reset:
- While RST is sampled high: state goes to RUN, redirect_pend clears, halted=0.
- All outputs are forced to 0 combinationally while RST=1.

Definitions:
- mem_ok = !mem_req || dhit
- go = ihit && mem_ok && state!=HALTED

Load-use hazard:
- lu = ex_mem2reg && ex_regwen && ex_wsel!=0 && (ex_wsel==if_rs || (if_uses_rt && ex_wsel==if_rt)).

Redirect:
- redir = ex_redirect || redirect_pend.

Outputs (combinational from state and inputs):
- advance = go.
- flush = go && redir.
- stall = go && lu && !redir. Flush has priority over stall.
- pc_en = go && !stall. The PC loads the target on flush cycles.
- halted = (state==HALTED).

Transitions:
- RUN → MEMWAIT when mem_req && !dhit.
- MEMWAIT → RUN on dhit.
- Any state → HALTED when wb_halt && go. HALTED is left only by RST.
- A wb_halt seen while !go is ignored until a go cycle.

redirect_pend:
- Set when ex_redirect=1 and go=0.
- Cleared on the go cycle that issues flush.
- ex_redirect asserted again while already pending does not double-flush.

Latency and counts:
- Load-use costs exactly one stall cycle. On the next go cycle the load is in MEM and lu drops naturally.
- A redirect costs exactly one flush cycle.
- A simultaneous redirect and load-use yields flush only, no stall.

Other rules:
- ihit=0 in any state: advance=0, pc_en=0, no state change except redirect_pend capture.
- ex_wsel==0 never triggers a stall.
- Assertion of RST mid-MEMWAIT or mid-HALTED returns the block to RUN with no residual flush.

Optional Feature:
Macro HAZARD_PERF_EN.
- Defined:
  - Adds outputs stall_cnt[CNT_W] and flush_cnt[CNT_W], plus a wait_cnt[CNT_W] counting cycles with go=0 and state!=HALTED.
  - Each counter increments by 1 on its cycle and saturates at all-ones.
  - All counters clear on RST and freeze in HALTED.
- Undefined: no counter logic or ports exist. Core behaviour is identical either way.

Test Plan:
1. Load-use: ihit=1, mem_req=0, ex_mem2reg=1, ex_regwen=1, ex_wsel=5, if_rs=5 → stall=1, pc_en=0, advance=1 for one cycle. Next cycle with ex_mem2reg=0 → stall=0.
2. Zero register: same as scenario 1 but ex_wsel=0, if_rs=0 → stall=0 throughout. Also if_rt=5 with if_uses_rt=0 → no stall.
3. Memory wait with redirect:
   - mem_req=1, dhit=0 for 3 cycles with ex_redirect pulsed in cycle 1 → advance=0 and flush=0 for those 3 cycles, state=MEMWAIT.
   - dhit=1 in cycle 4 → flush=1, advance=1 for exactly one cycle, then flush=0.
4. Priority: ex_redirect=1 together with a load-use match, ihit=1 → flush=1, stall=0, pc_en=1.
5. Halt:
   - wb_halt=1 on a go cycle → halted=1 from the next cycle.
   - advance, pc_en, stall and flush stay 0 regardless of ihit/dhit for 10 cycles.
   - RST=1 for one cycle → halted=0 and advance follows ihit again.
6. HAZARD_PERF_EN defined: 3 load-use stalls, 2 redirects and 4 dhit-miss cycles → stall_cnt=3, flush_cnt=2, wait_cnt=4. RST clears all three to 0.
